// File: rtl/writeback_queue_pkg.sv
// Shared types and defaults for the writeback queue and its lookup matchers.
// The entry type is the reference layout {addr, data} at the default data width.
package writeback_queue_pkg;

  localparam int REG_ADDR_W  = 5;
  localparam int WBQ_DATA_W  = 32;
  localparam int WBQ_DEPTH   = 4;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [WBQ_DATA_W-1:0] data;
  } wbq_entry_t;

  // Register 0 is hardwired to zero, so it is never queued and never matched.
  function automatic logic addr_live(input logic [REG_ADDR_W-1:0] a);
    return a != '0;
  endfunction

endpackage

// File: rtl/writeback_lookup.sv
// Priority matcher: finds the youngest valid entry whose address equals i_lookup.
// Entries are scanned oldest-to-youngest from the tail so the last match wins.
module writeback_lookup
  import writeback_queue_pkg::*;
#(
  parameter int DEPTH  = WBQ_DEPTH,
  parameter int DATA_W = WBQ_DATA_W,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][REG_ADDR_W-1:0] i_addrs,
  input  logic [DEPTH-1:0][DATA_W-1:0]     i_datas,
  input  logic [DEPTH-1:0]                 i_valid,
  input  logic [PTR_W-1:0]                 i_tail,
  input  logic [REG_ADDR_W-1:0]            i_lookup,
  output logic                             o_hit,
  output logic [DATA_W-1:0]                o_data
);

  logic [PTR_W-1:0] w_idx;

  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    w_idx  = '0;
    // k = DEPTH is the oldest slot when full; k = 1 is the most recent push.
    for (int k = DEPTH; k >= 1; k--) begin
      w_idx = i_tail - PTR_W'(k);
      if (i_valid[w_idx] && addr_live(i_lookup) && (i_addrs[w_idx] == i_lookup)) begin
        o_hit  = 1'b1;
        o_data = i_datas[w_idx];
      end
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// Pending register-file write queue with forwarding lookup for two read ports.
// Handshake: a result transfers on a rising edge where in_valid && in_ready.
module writeback_queue
  import writeback_queue_pkg::*;
#(
  parameter int DEPTH  = WBQ_DEPTH,
  parameter int DATA_W = WBQ_DATA_W
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        in_valid,
  input  logic [REG_ADDR_W-1:0]       in_reg,
  input  logic [DATA_W-1:0]           in_data,
  output logic                        in_ready,
  input  logic                        drain_enable,
  output logic [REG_ADDR_W-1:0]       reg_write,
  output logic [DATA_W-1:0]           data_write,
  output logic                        write_enable,
  input  logic [REG_ADDR_W-1:0]       lookup_reg1,
  input  logic [REG_ADDR_W-1:0]       lookup_reg2,
  output logic                        hit1,
  output logic                        hit2,
  output logic [DATA_W-1:0]           hit_data1,
  output logic [DATA_W-1:0]           hit_data2,
  output logic [$clog2(DEPTH):0]      pending
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][REG_ADDR_W-1:0] r_addr;
  logic [DEPTH-1:0][DATA_W-1:0]     r_data;
  logic [PTR_W-1:0]                 r_head;
  logic [PTR_W-1:0]                 r_tail;
  logic [CNT_W-1:0]                 r_count;

  logic             w_full;
  logic             w_empty;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic [DEPTH-1:0] w_valid;
  logic [PTR_W-1:0] w_off;

  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_empty  = (r_count == '0);
  // Full blocks acceptance even when a pop frees a slot on the same edge.
  assign in_ready = !w_full;
  assign w_accept = in_valid && in_ready;
  assign w_push   = w_accept && addr_live(in_reg);
  assign w_pop    = !w_empty && drain_enable;

  assign write_enable = w_pop;
  assign reg_write    = w_empty ? '0 : r_addr[r_head];
  assign data_write   = w_empty ? '0 : r_data[r_head];
  assign pending      = r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; validity comes solely from head/count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= in_reg;
      r_data[r_tail] <= in_data;
    end
  end

  always_comb begin
    w_valid = '0;
    w_off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off      = PTR_W'(i) - r_head;
      w_valid[i] = ({1'b0, w_off} < r_count);
    end
  end

  writeback_lookup #(.DEPTH(DEPTH), .DATA_W(DATA_W), .PTR_W(PTR_W)) u_lookup1 (
    .i_addrs  (r_addr),
    .i_datas  (r_data),
    .i_valid  (w_valid),
    .i_tail   (r_tail),
    .i_lookup (lookup_reg1),
    .o_hit    (hit1),
    .o_data   (hit_data1)
  );

  writeback_lookup #(.DEPTH(DEPTH), .DATA_W(DATA_W), .PTR_W(PTR_W)) u_lookup2 (
    .i_addrs  (r_addr),
    .i_datas  (r_data),
    .i_valid  (w_valid),
    .i_tail   (r_tail),
    .i_lookup (lookup_reg2),
    .o_hit    (hit2),
    .o_data   (hit_data2)
  );

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: queue-based reference of pending writes, checked every
// falling edge against drain output, occupancy, ready and both lookup ports.
module tb_writeback_queue;
  import writeback_queue_pkg::*;

  localparam int DEPTH = WBQ_DEPTH;
  localparam int DW    = WBQ_DATA_W;
  localparam int W     = $bits(wbq_entry_t);

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  in_valid;
  logic [REG_ADDR_W-1:0] in_reg;
  logic [DW-1:0]         in_data;
  logic                  in_ready;
  logic                  drain_enable;
  logic [REG_ADDR_W-1:0] reg_write;
  logic [DW-1:0]         data_write;
  logic                  write_enable;
  logic [REG_ADDR_W-1:0] lookup_reg1;
  logic [REG_ADDR_W-1:0] lookup_reg2;
  logic                  hit1;
  logic                  hit2;
  logic [DW-1:0]         hit_data1;
  logic [DW-1:0]         hit_data2;
  logic [$clog2(DEPTH):0] pending;

  writeback_queue #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_reg       (in_reg),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .drain_enable (drain_enable),
    .reg_write    (reg_write),
    .data_write   (data_write),
    .write_enable (write_enable),
    .lookup_reg1  (lookup_reg1),
    .lookup_reg2  (lookup_reg2),
    .hit1         (hit1),
    .hit2         (hit2),
    .hit_data1    (hit_data1),
    .hit_data2    (hit_data2),
    .pending      (pending)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_writes = 0;
  int m_count = 0;
  bit acc_flag = 1'b0;
  logic [W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void ref_lookup(input logic [REG_ADDR_W-1:0] a,
                                     output logic h, output logic [DW-1:0] d);
    wbq_entry_t e;
    h = 1'b0;
    d = '0;
    if (a != '0) begin
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        e = wbq_entry_t'(exp_q[i]);
        if (e.addr == a) begin
          h = 1'b1;
          d = e.data;
          break;
        end
      end
    end
  endfunction

  // scoreboard: compare, then advance the model by the upcoming edge
  always @(negedge clk) begin
    logic          h;
    logic [DW-1:0] d;
    logic          m_we;
    wbq_entry_t    e;
    if (!reset_n) begin
      check_eq("rst_pending", pending, 0);
      check_eq("rst_we", write_enable, 0);
      check_eq("rst_reg", reg_write, 0);
      check_eq("rst_data", data_write, 0);
      check_eq("rst_hit1", hit1, 0);
      check_eq("rst_hit2", hit2, 0);
      check_eq("rst_ready", in_ready, 1);
      exp_q.delete();
      m_count  = 0;
      acc_flag = 1'b0;
    end else begin
      check_eq("pending", pending, m_count);
      check_eq("in_ready", in_ready, m_count < DEPTH);
      ref_lookup(lookup_reg1, h, d);
      check_eq("hit1", hit1, h);
      check_eq("hit_data1", hit_data1, d);
      ref_lookup(lookup_reg2, h, d);
      check_eq("hit2", hit2, h);
      check_eq("hit_data2", hit_data2, d);
      m_we = (m_count != 0) && drain_enable;
      check_eq("write_enable", write_enable, m_we);
      if (m_we) begin
        e = wbq_entry_t'(exp_q.pop_front());
        check_eq("reg_write", reg_write, e.addr);
        check_eq("data_write", data_write, e.data);
        n_writes++;
      end else if (m_count == 0) begin
        check_eq("idle_reg", reg_write, 0);
        check_eq("idle_data", data_write, 0);
      end
      acc_flag = in_valid && (m_count < DEPTH);
      if (acc_flag && in_reg != '0) exp_q.push_back({in_reg, in_data});
      m_count = exp_q.size();
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [REG_ADDR_W-1:0] r, input logic [DW-1:0] d);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_reg   = r;
    in_data  = d;
    for (int t = 0; t < 50; t++) begin
      @(posedge clk);
      if (acc_flag) begin
        done = 1'b1;
        break;
      end
    end
    check_eq("push_accepted", done, 1);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int w0;
    reset_n      = 1'b0;
    in_valid     = 1'b0;
    in_reg       = '0;
    in_data      = '0;
    drain_enable = 1'b0;
    lookup_reg1  = '0;
    lookup_reg2  = '0;
    step(2);
    reset_n = 1'b1;
    step(1);

    // single push drains on the following cycle
    drain_enable = 1'b1;
    w0 = n_writes;
    push(5'd5, 32'h0000_000A);
    step(3);
    check_eq("single_write_count", n_writes - w0, 1);

    // fill with drain held off, full rejects, then ordered drain
    drain_enable = 1'b0;
    push(5'd1, 32'd10);
    push(5'd2, 32'd20);
    push(5'd3, 32'd30);
    push(5'd4, 32'd40);
    in_valid = 1'b1;
    in_reg   = 5'd9;
    in_data  = 32'd99;
    step(2);
    check_eq("full_reject", acc_flag, 0);
    check_eq("full_pending", pending, 4);
    in_valid     = 1'b0;
    drain_enable = 1'b1;
    w0 = n_writes;
    step(6);
    check_eq("fill_drain_count", n_writes - w0, 4);

    // youngest-wins lookup
    drain_enable = 1'b0;
    lookup_reg1  = 5'd7;
    lookup_reg2  = 5'd8;
    push(5'd7, 32'h11);
    push(5'd7, 32'h22);
    step(1);
    check_eq("young_hit1", hit1, 1);
    check_eq("young_data1", hit_data1, 32'h22);
    check_eq("miss_hit2", hit2, 0);
    drain_enable = 1'b1;
    step(1);
    step(2);

    // register 0 handshake without enqueue
    lookup_reg1 = 5'd0;
    push(5'd0, 32'hFFFF_FFFF);
    step(2);
    check_eq("r0_pending", pending, 0);

    // full queue with continuous pushes through pointer wrap
    drain_enable = 1'b0;
    for (int i = 1; i <= 4; i++) push(5'(i + 10), $urandom);
    drain_enable = 1'b1;
    for (int i = 1; i <= 12; i++) push(5'(i), $urandom);
    step(6);
    check_eq("wrap_empty", pending, 0);

    // asynchronous reset mid-operation
    drain_enable = 1'b0;
    push(5'd3, 32'h33);
    push(5'd4, 32'h44);
    push(5'd6, 32'h66);
    drain_enable = 1'b1;
    #1;
    check_eq("pre_rst_we", write_enable, 1);
    #1;
    reset_n = 1'b0;
    #1;
    check_eq("async_rst_we", write_enable, 0);
    check_eq("async_rst_pending", pending, 0);
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    w0 = n_writes;
    step(5);
    check_eq("no_stale_writes", n_writes - w0, 0);

    // random traffic
    for (int c = 0; c < 200; c++) begin
      in_valid     = 1'($urandom_range(0, 1));
      in_reg       = 5'($urandom_range(0, 7));
      in_data      = $urandom;
      drain_enable = ($urandom_range(0, 3) != 0);
      lookup_reg1  = 5'($urandom_range(0, 7));
      lookup_reg2  = 5'($urandom_range(0, 7));
      step(1);
    end
    in_valid     = 1'b0;
    drain_enable = 1'b1;
    step(8);
    check_eq("final_empty", pending, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of pending-write entries; power of two, 2..16.
REQ-002 Parameter DATA_W, default 32, write data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  producer offers a result this cycle.
REQ-006 in_reg  input  5  destination register address of offered result.
REQ-007 in_data  input  DATA_W  offered result value.
REQ-008 in_ready  output  1  queue can accept; high iff count < DEPTH.
REQ-009 drain_enable  input  1  register-file write port is free this cycle.
REQ-010 reg_write  output  5  register address to write; head entry address.
REQ-011 data_write  output  DATA_W  data to write; head entry data.
REQ-012 write_enable  output  1  register-file write strobe.
REQ-013 lookup_reg1, lookup_reg2  input  5 each  read addresses to check against pending writes.
REQ-014 hit1, hit2  output  1 each  pending write exists for lookup address.
REQ-015 hit_data1, hit_data2  output  DATA_W each  youngest pending data for lookup address.
REQ-016 pending  output  clog2(DEPTH)+1  current entry count.

Function
REQ-017 Accept = in_valid && in_ready; on accept with in_reg != 0, entry {in_reg, in_data} written at tail, tail advances.
REQ-018 Accept with in_reg == 0 completes the handshake but enqueues nothing (register 0 is constant zero).
REQ-019 write_enable = (pending != 0) && drain_enable, combinational.
REQ-020 reg_write/data_write reflect head entry combinationally; 0 when empty.
REQ-021 Pop on rising edge when write_enable high; head advances.
REQ-022 Latency: result accepted at edge N is presented at reg_write no earlier than cycle after edge N; no input-to-output pass-through when empty.
REQ-023 Simultaneous accept and pop: count unchanged; both pointers advance.
REQ-024 Full (pending == DEPTH): in_ready low, even if a pop occurs the same cycle.
REQ-025 Pointers wrap modulo DEPTH; FIFO order strictly preserved.
REQ-026 Lookup combinational over all valid entries; youngest matching entry (closest to tail) wins.
REQ-027 Lookup address 0 never hits; hit low forces hit_data to 0.
REQ-028 Entry being popped this cycle still counts for lookup this cycle.
REQ-029 Multiple pending writes to one register are all drained in order; none merged.

Reset
REQ-030 reset_n low immediately clears head, tail, count; pending = 0, write_enable = 0, reg_write = 0, data_write = 0, hit1/hit2 = 0, in_ready = 1.
REQ-031 Reset asserted mid-operation discards all pending entries; no write strobe issued for them.
REQ-032 Entry storage need not be cleared; only valid tracking is reset.

Structure
REQ-033 Shared package holds REG_ADDR_W = 5, DATA_W default, DEPTH default, and the entry type {addr, data}.
REQ-034 One sub-module writeback_lookup: priority matcher of one address against entry array, valid mask, and tail pointer; instantiated twice.
REQ-035 No other sub-modules; FIFO control inline.

Verification
REQ-036 Reset then push {r5, 0x0000000A}, drain_enable = 1 -> next cycle write_enable = 1, reg_write = 5, data_write = 0xA; following cycle pending = 0.
REQ-037 drain_enable = 0, push r1..r4 (data 10,20,30,40) -> pending = 4, in_ready = 0; fifth offer not accepted; enable drain -> writes r1..r4 in order on four consecutive cycles.
REQ-038 Push r7=0x11 then r7=0x22, drain held off, lookup_reg1 = 7 -> hit1 = 1, hit_data1 = 0x22; lookup_reg2 = 8 -> hit2 = 0, hit_data2 = 0.
REQ-039 Push {r0, 0xFFFFFFFF} -> in_ready high, pending stays 0, write_enable never asserts, lookup of r0 never hits.
REQ-040 Full queue, drain active, continuous pushes of 12 entries -> pointers wrap at least twice, output order equals input order, count never exceeds 4.
REQ-041 Three entries pending, pulse reset_n low between edges -> write_enable and pending drop to 0 immediately; no stale writes after release.
